// File: rtl/interrupt_acceptor.sv
// Core-side interrupt acceptor: qualifies controller requests against mstatus.MIE,
// traps at the next retire boundary and returns to the saved PC on mret.
module interrupt_acceptor #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            interrupt,
  input  logic [XLEN-1:0] intCode,
  input  logic            globalEnable,
  input  logic            instrRetire,
  input  logic [XLEN-1:0] retirePc,
  input  logic [XLEN-1:0] trapVector,
  input  logic            mret,
  output logic            redirectValid,
  output logic [XLEN-1:0] redirectPc,
  output logic [XLEN-1:0] trapCause,
  output logic [XLEN-1:0] trapEpc,
  output logic            irqAck,
  output logic            inHandler
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic [XLEN-1:0] r_trap_cause;
  logic [XLEN-1:0] r_trap_epc;
  logic            r_irq_ack;
  logic            r_in_handler;

  state_t          w_state_nxt;
  logic            w_redirect_valid_nxt;
  logic [XLEN-1:0] w_redirect_pc_nxt;
  logic [XLEN-1:0] w_trap_cause_nxt;
  logic [XLEN-1:0] w_trap_epc_nxt;
  logic            w_irq_ack_nxt;
  logic            w_in_handler_nxt;

  logic            w_request;
  logic [XLEN-1:0] w_entry_epc;
  logic [XLEN-1:0] w_entry_vector;
  logic            w_unused;

  assign w_request      = interrupt && globalEnable;
  // Return PC is word aligned, so only the upper bits take part in the +4.
  assign w_entry_epc    = {retirePc[XLEN-1:2] + (XLEN-2)'(1), 2'b00};
  assign w_entry_vector = {trapVector[XLEN-1:2], 2'b00};
  assign w_unused       = ^{retirePc[1:0], trapVector[1:0], intCode[XLEN-1]};

  // The cause is built from the code presented in the retire cycle itself, which
  // is always the most recent one, so no separate copy of the pending code is held.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    w_state_nxt          = r_state;
    w_redirect_valid_nxt = 1'b0;
    w_irq_ack_nxt        = 1'b0;
    w_redirect_pc_nxt    = r_redirect_pc;
    w_trap_cause_nxt     = r_trap_cause;
    w_trap_epc_nxt       = r_trap_epc;
    w_in_handler_nxt     = r_in_handler;

    unique case (r_state)
      IDLE: begin
        if (w_request) w_state_nxt = PENDING;
      end
      PENDING: begin
        if (!w_request) begin
          w_state_nxt = IDLE;
        end else if (instrRetire) begin
          w_state_nxt          = HANDLER;
          w_trap_cause_nxt     = {1'b1, intCode[XLEN-2:0]};
          w_trap_epc_nxt       = w_entry_epc;
          w_redirect_pc_nxt    = w_entry_vector;
          w_redirect_valid_nxt = 1'b1;
          w_irq_ack_nxt        = 1'b1;
          w_in_handler_nxt     = 1'b1;
        end
      end
      HANDLER: begin
        if (mret) begin
          w_state_nxt          = IDLE;
          w_redirect_pc_nxt    = r_trap_epc;
          w_redirect_valid_nxt = 1'b1;
          w_in_handler_nxt     = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state          <= IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_trap_cause     <= '0;
      r_trap_epc       <= '0;
      r_irq_ack        <= 1'b0;
      r_in_handler     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state          <= w_state_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
      r_trap_cause     <= w_trap_cause_nxt;
      r_trap_epc       <= w_trap_epc_nxt;
      r_irq_ack        <= w_irq_ack_nxt;
      r_in_handler     <= w_in_handler_nxt;
    end
  end

  assign redirectValid = r_redirect_valid;
  assign redirectPc    = r_redirect_pc;
  assign trapCause     = r_trap_cause;
  assign trapEpc       = r_trap_epc;
  assign irqAck        = r_irq_ack;
  assign inHandler     = r_in_handler;

endmodule

// File: tb/tb_interrupt_acceptor.sv
// Self-checking bench for interrupt_acceptor: directed scenarios followed by random
// traffic, all compared against a behavioural model of the trap/return rules.
module tb_interrupt_acceptor;

  logic        clk = 1'b0;
  logic        resetN;
  logic        interrupt;
  logic [31:0] intCode;
  logic        globalEnable;
  logic        instrRetire;
  logic [31:0] retirePc;
  logic [31:0] trapVector;
  logic        mret;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic [31:0] trapCause;
  logic [31:0] trapEpc;
  logic        irqAck;
  logic        inHandler;

  int checks   = 0;
  int failures = 0;

  // Reference model: a request is "armed" once seen qualified; a trap is "open"
  // between entry and mret.
  bit          m_armed;
  bit          m_open;
  bit          m_rv;
  bit          m_ack;
  logic [31:0] m_rpc;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  interrupt_acceptor #(.XLEN(32)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .interrupt    (interrupt),
    .intCode      (intCode),
    .globalEnable (globalEnable),
    .instrRetire  (instrRetire),
    .retirePc     (retirePc),
    .trapVector   (trapVector),
    .mret         (mret),
    .redirectValid(redirectValid),
    .redirectPc   (redirectPc),
    .trapCause    (trapCause),
    .trapEpc      (trapEpc),
    .irqAck       (irqAck),
    .inHandler    (inHandler)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_open = 0; m_rv = 0; m_ack = 0;
    m_rpc = '0; m_cause = '0; m_epc = '0;
  endtask

  task automatic model_edge();
    bit req;
    req   = interrupt && globalEnable;
    m_rv  = 0;
    m_ack = 0;
    if (m_open) begin
      if (mret) begin
        m_rv   = 1;
        m_rpc  = m_epc;
        m_open = 0;
      end
    end else if (m_armed) begin
      if (!req) begin
        m_armed = 0;
      end else if (instrRetire) begin
        m_cause = 32'h8000_0000 | (intCode & 32'h7FFF_FFFF);
        m_epc   = (retirePc + 32'd4) & 32'hFFFF_FFFC;
        m_rpc   = trapVector & 32'hFFFF_FFFC;
        m_rv    = 1;
        m_ack   = 1;
        m_open  = 1;
        m_armed = 0;
      end
    end else if (req) begin
      m_armed = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".redirectValid"}, 32'(redirectValid), 32'(m_rv));
    check({tag, ".irqAck"},        32'(irqAck),        32'(m_ack));
    check({tag, ".inHandler"},     32'(inHandler),     32'(m_open));
    check({tag, ".redirectPc"},    redirectPc,         m_rpc);
    check({tag, ".trapCause"},     trapCause,          m_cause);
    check({tag, ".trapEpc"},       trapEpc,            m_epc);
  endtask

  // One clock: model steps on the inputs the DUT sampled, outputs compared 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    interrupt = 0; intCode = '0; globalEnable = 0; instrRetire = 0;
    retirePc = '0; trapVector = '0; mret = 0;
  endtask

  initial begin
    idle_inputs();
    resetN = 0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    resetN = 1;

    // Scenario 1: request, retire on the third cycle.
    @(posedge clk); #1;
    interrupt = 1; intCode = 32'd7; globalEnable = 1; trapVector = 32'h80;
    cycle("s1.c1");
    cycle("s1.c2");
    instrRetire = 1; retirePc = 32'h100;
    cycle("s1.trap");
    check("s1.valid", 32'(redirectValid), 32'd1);
    check("s1.ack", 32'(irqAck), 32'd1);
    check("s1.rpc", redirectPc, 32'h80);
    check("s1.cause", trapCause, 32'h8000_0007);
    check("s1.epc", trapEpc, 32'h104);
    instrRetire = 0;
    cycle("s1.after");
    check("s1.pulse_once", 32'(redirectValid), 32'd0);
    check("s1.handler", 32'(inHandler), 32'd1);

    // Scenario 2: mret return, then a second mret is ignored.
    interrupt = 0; mret = 1;
    cycle("s2.mret");
    check("s2.valid", 32'(redirectValid), 32'd1);
    check("s2.rpc", redirectPc, 32'h104);
    check("s2.handler", 32'(inHandler), 32'd0);
    mret = 0;
    cycle("s2.idle");
    mret = 1;
    cycle("s2.mret2");
    check("s2.no_redirect", 32'(redirectValid), 32'd0);
    mret = 0;

    // Scenario 3: disabled request with retires is never taken.
    interrupt = 1; intCode = 32'd3; globalEnable = 0;
    for (int i = 0; i < 10; i++) begin
      instrRetire = i[0]; retirePc = 32'h200 + 32'(i * 4);
      cycle("s3.disabled");
      check("s3.no_ack", 32'(irqAck), 32'd0);
    end
    globalEnable = 1; instrRetire = 1; retirePc = 32'h300;
    cycle("s3.arm");
    cycle("s3.trap");
    check("s3.taken", 32'(irqAck), 32'd1);
    check("s3.epc", trapEpc, 32'h304);
    instrRetire = 0; interrupt = 0; mret = 1;
    cycle("s3.ret");
    mret = 0;

    // Scenario 4: cancel in the retire cycle, by interrupt then by enable.
    interrupt = 1; globalEnable = 1; intCode = 32'd9;
    cycle("s4a.arm");
    interrupt = 0; instrRetire = 1;
    cycle("s4a.cancel");
    check("s4a.no_trap", 32'(redirectValid), 32'd0);
    instrRetire = 0;
    cycle("s4a.idle");
    interrupt = 1;
    cycle("s4b.arm");
    globalEnable = 0; instrRetire = 1;
    cycle("s4b.cancel");
    check("s4b.no_ack", 32'(irqAck), 32'd0);
    instrRetire = 0; globalEnable = 1;
    cycle("s4b.rearm");
    check("s4b.not_in_handler", 32'(inHandler), 32'd0);

    // Scenario 5: EPC wrap and vector alignment.
    instrRetire = 1; retirePc = 32'hFFFF_FFFC; trapVector = 32'h83; intCode = 32'hFFFF_FFFF;
    cycle("s5.trap");
    check("s5.epc_wrap", trapEpc, 32'h0);
    check("s5.vector", redirectPc, 32'h80);
    check("s5.cause_msb", trapCause, 32'hFFFF_FFFF);
    instrRetire = 0;
    cycle("s5.hold");

    // Scenario 6: asynchronous reset in the handler, then scenario 1 timing again.
    #3;
    resetN = 0;
    #1;
    model_reset();
    compare_all("s6.async");
    check("s6.cause_zero", trapCause, 32'h0);
    #2;
    resetN = 1;
    interrupt = 1; intCode = 32'd7; globalEnable = 1; trapVector = 32'h80; retirePc = 32'h100;
    cycle("s6.c1");
    cycle("s6.c2");
    instrRetire = 1;
    cycle("s6.trap");
    check("s6.ack", 32'(irqAck), 32'd1);
    instrRetire = 0; interrupt = 0; mret = 1;
    cycle("s6.ret");
    mret = 0;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      interrupt    = ($urandom_range(0, 3) != 0);
      globalEnable = ($urandom_range(0, 5) != 0);
      instrRetire  = ($urandom_range(0, 1) == 1);
      mret         = ($urandom_range(0, 4) == 0);
      intCode      = $urandom();
      retirePc     = $urandom();
      trapVector   = $urandom();
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
